// File: rtl/teleferico_cond_entradas.sv
// Input conditioning for the teleferico controller: sync, debounce, ready latches, tick, sensor-fault FSM.
// Optional debug ports (dbg_state, dbg_changes) are enabled by defining TELEFERICO_DBG_EN.
module teleferico_cond_entradas #(
    parameter int unsigned DEB_CYCLES  = 4,
    parameter int unsigned TICK_DIV    = 8,
    parameter int unsigned FAULT_TICKS = 3
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [5:0] raw_in,
    input  logic       ready_ack,
    input  logic       fault_clr,
    output logic       tick,
    output logic       A_pronta,
    output logic       B_pronta,
    output logic       perto_base,
    output logic       perto_topo,
    output logic       chegou_base,
    output logic       chegou_topo,
    output logic       changed,
    output logic       sensor_fault
`ifdef TELEFERICO_DBG_EN
    ,
    output logic [1:0] dbg_state,
    output logic [7:0] dbg_changes
`endif
);

    localparam int unsigned DW = $clog2(DEB_CYCLES) + 1;
    localparam int unsigned TW = $clog2(TICK_DIV) + 1;
    localparam int unsigned FW = $clog2(FAULT_TICKS) + 1;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } fstate_e;

    logic [5:0]         sync1_q, sync2_q;
    logic [5:0]         stable_q, stable_d, stable_dly_q;
    logic [5:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         ready_q, ready_d;
    logic               changed_q, changed_d;
    logic [TW-1:0]      tick_cnt_q, tick_cnt_d;
    logic               tick_q, tick_d;
    logic [FW-1:0]      fcnt_q, fcnt_d, fcnt_inc;
    fstate_e            state_q, state_d;
    logic               implausible;

    // A bit flips only after DEB_CYCLES consecutive cycles of disagreement with its stable value.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1))
                    stable_d[i] = sync2_q[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        changed_d  = |(stable_q[5:2] ^ stable_dly_q[5:2]);
        ready_d    = (stable_q[1:0] & ~stable_dly_q[1:0]) | (ready_q & {2{~ready_ack}});
        tick_d     = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick_d ? '0 : tick_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            deb_cnt_q    <= '0;
            ready_q      <= '0;
            changed_q    <= 1'b0;
            tick_cnt_q   <= '0;
            tick_q       <= 1'b0;
        end else begin
            sync1_q      <= raw_in;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            deb_cnt_q    <= deb_cnt_d;
            ready_q      <= ready_d;
            changed_q    <= changed_d;
            tick_cnt_q   <= tick_cnt_d;
            tick_q       <= tick_d;
        end
    end

    assign implausible = (stable_q[4] & ~stable_q[2]) | (stable_q[5] & ~stable_q[3]);

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset) begin
            state_q <= ST_OK;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // The registered tick is the time base, so fault assertion lands the cycle after that tick.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        fcnt_inc = fcnt_q + 1'b1;
        case (state_q)
            ST_OK: begin
                if (tick_q && implausible) begin
                    if (FAULT_TICKS == 1) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_SUSPECT;
                        fcnt_d  = FW'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                if (tick_q) begin
                    if (!implausible) begin
                        state_d = ST_OK;
                        fcnt_d  = '0;
                    end else begin
                        fcnt_d = fcnt_inc;
                        if (fcnt_inc == FW'(FAULT_TICKS))
                            state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr && !implausible) begin
                    state_d = ST_OK;
                    fcnt_d  = '0;
                end
            end
            default: begin
                state_d = ST_OK;
                fcnt_d  = '0;
            end
        endcase
    end

    always_comb begin
        sensor_fault = (state_q == ST_FAULT);
    end

    assign tick        = tick_q;
    assign A_pronta    = ready_q[0];
    assign B_pronta    = ready_q[1];
    assign perto_base  = stable_q[2];
    assign perto_topo  = stable_q[3];
    assign chegou_base = stable_q[4];
    assign chegou_topo = stable_q[5];
    assign changed     = changed_q;

`ifdef TELEFERICO_DBG_EN
    logic [7:0] dbg_changes_q;

    always_ff @(posedge clk_2 or negedge reset) begin
        if (!reset)
            dbg_changes_q <= '0;
        else if (changed_q && (dbg_changes_q != '1))
            dbg_changes_q <= dbg_changes_q + 1'b1;
    end

    assign dbg_state   = state_q;
    assign dbg_changes = dbg_changes_q;
`endif

endmodule

// File: tb/tb_teleferico_cond_entradas.sv
// Directed bench for teleferico_cond_entradas: vector table for debounce/ready latches,
// hand-written sequences for tick, asynchronous reset and the sensor-fault FSM.
module tb_teleferico_cond_entradas;

    logic       clk_2;
    logic       reset;
    logic [5:0] raw_in;
    logic       ready_ack;
    logic       fault_clr;
    logic       tick, A_pronta, B_pronta;
    logic       perto_base, perto_topo, chegou_base, chegou_topo;
    logic       changed, sensor_fault;
`ifdef TELEFERICO_DBG_EN
    logic [1:0] dbg_state;
    logic [7:0] dbg_changes;
`endif

    int checks   = 0;
    int failures = 0;

    teleferico_cond_entradas #(
        .DEB_CYCLES (4),
        .TICK_DIV   (8),
        .FAULT_TICKS(3)
    ) dut (
        .clk_2       (clk_2),
        .reset       (reset),
        .raw_in      (raw_in),
        .ready_ack   (ready_ack),
        .fault_clr   (fault_clr),
        .tick        (tick),
        .A_pronta    (A_pronta),
        .B_pronta    (B_pronta),
        .perto_base  (perto_base),
        .perto_topo  (perto_topo),
        .chegou_base (chegou_base),
        .chegou_topo (chegou_topo),
        .changed     (changed),
        .sensor_fault(sensor_fault)
`ifdef TELEFERICO_DBG_EN
        ,
        .dbg_state   (dbg_state),
        .dbg_changes (dbg_changes)
`endif
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0] raw;
        logic       ack;
        logic       exp_pb;
        logic       exp_chg;
        logic       exp_a;
        logic       exp_b;
    } vec_t;

    localparam int NVEC = 45;
    vec_t tbl [NVEC];

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " tick"}, tick, 1'b0);
        chk({tag, " A_pronta"}, A_pronta, 1'b0);
        chk({tag, " B_pronta"}, B_pronta, 1'b0);
        chk({tag, " perto_base"}, perto_base, 1'b0);
        chk({tag, " perto_topo"}, perto_topo, 1'b0);
        chk({tag, " chegou_base"}, chegou_base, 1'b0);
        chk({tag, " chegou_topo"}, chegou_topo, 1'b0);
        chk({tag, " changed"}, changed, 1'b0);
        chk({tag, " sensor_fault"}, sensor_fault, 1'b0);
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        raw_in    = '0;
        ready_ack = 1'b0;
        fault_clr = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        bit found;

        // Record i: inputs sampled at edge i, outputs checked just after it.
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].raw     = '0;
            tbl[i].raw[2]  = (i <= 2) || (i >= 8);
            tbl[i].raw[0]  = (i >= 16 && i <= 25) || (i >= 35);
            tbl[i].raw[1]  = (i >= 16 && i <= 25);
            tbl[i].ack     = (i == 33) || (i == 41) || (i == 43);
            tbl[i].exp_pb  = (i >= 13);
            tbl[i].exp_chg = (i == 14);
            tbl[i].exp_a   = (i >= 22 && i <= 32) || (i >= 41 && i <= 42);
            tbl[i].exp_b   = (i >= 22 && i <= 32);
        end

        reset     = 1'b0;
        raw_in    = '0;
        ready_ack = 1'b0;
        fault_clr = 1'b0;
        #1;
        chk_all_zero("reset_state");
        step();
        step();
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            raw_in    = tbl[i].raw;
            ready_ack = tbl[i].ack;
            step();
            chk($sformatf("vec%0d perto_base", i), perto_base, tbl[i].exp_pb);
            chk($sformatf("vec%0d changed", i), changed, tbl[i].exp_chg);
            chk($sformatf("vec%0d A_pronta", i), A_pronta, tbl[i].exp_a);
            chk($sformatf("vec%0d B_pronta", i), B_pronta, tbl[i].exp_b);
        end
        ready_ack = 1'b0;

        // Assert reset asynchronously while tick and perto_base are both high.
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            step();
            if (tick === 1'b1) found = 1'b1;
        end
        chk("tick_seen_before_reset", found, 1'b1);
        chk("perto_base_before_reset", perto_base, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_reset");

        raw_in = '0;
        step();
        step();
        reset = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            chk($sformatf("tick_k%0d", k), tick, (k % 8) == 0);
        end

        // Fault sequence: chegou_topo held high; perto_topo toggled to build the scenarios.
        apply_reset();
        for (int k = 1; k <= 100; k++) begin
            raw_in    = 6'b100000;
            raw_in[3] = (k >= 29 && k <= 37) || (k >= 58 && k <= 65) || (k >= 74);
            fault_clr = (k == 27) || (k == 37);
            step();
            chk($sformatf("fault_k%0d", k), sensor_fault, (k >= 25) && (k <= 36));
        end
        fault_clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
